// File: rtl/bcdsub_seq.sv
// Digit-serial packed-BCD subtractor: |a - b| with sign and invalid-digit flags,
// one digit per clock, LSD first, with a ten's-complement fix-up pass when a < b.
module bcdsub_seq #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] diff,
  output logic              neg,
  output logic              err
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUB  = 2'd1;
  localparam logic [1:0] ST_CMP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Returns {borrow_out, digit}; the 5-bit difference wraps negative into bit 4.
  function automatic logic [4:0] bcd_digit_sub(input logic [3:0] x, input logic [3:0] y,
                                               input logic bin);
    logic [4:0] t;
    t = {1'b0, x} - {1'b0, y} - {4'd0, bin};
    if (t[4]) begin
      return {1'b1, t[3:0] + 4'd10};
    end else begin
      return {1'b0, t[3:0]};
    end
  endfunction

  function automatic logic has_bad_nibble(input logic [4*NDIG-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              borrow_q, borrow_d;
  logic [4*NDIG-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic              neg_q, neg_d, err_q, err_d;
  logic              out_valid_q, out_valid_d, in_ready_q, in_ready_d;

  logic [3:0]        x_s, y_s;
  logic [4:0]        step_s;
  logic              last_s;

  // Digit datapath shared by SUB and CMP: CMP subtracts the current result from zero.
  always_comb begin
    x_s = 4'd0;
    y_s = 4'd0;
    if (state_q == ST_SUB) begin
      x_s = 4'(a_q >> {idx_q, 2'b00});
      y_s = 4'(b_q >> {idx_q, 2'b00});
    end else begin
      x_s = 4'd0;
      y_s = 4'(diff_q >> {idx_q, 2'b00});
    end
    step_s = bcd_digit_sub(x_s, y_s, borrow_q);
    last_s = (idx_q == IW'(NDIG - 1));
  end

  // Next-state and register update logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    neg_d    = neg_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          idx_d    = '0;
          borrow_d = 1'b0;
          neg_d    = 1'b0;
          diff_d   = '0;
          if (has_bad_nibble(a) || has_bad_nibble(b)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ST_SUB;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SUB, ST_CMP: begin
        for (int i = 0; i < NDIG; i++) begin
          if (idx_q == IW'(i)) begin
            diff_d[4*i +: 4] = step_s[3:0];
          end else begin
            diff_d[4*i +: 4] = diff_q[4*i +: 4];
          end
        end
        if (!last_s) begin
          idx_d    = idx_q + IW'(1);
          borrow_d = step_s[4];
        end else if (state_q == ST_SUB && step_s[4]) begin
          // a < b: result is a ten's complement, convert it to magnitude.
          neg_d    = 1'b1;
          idx_d    = '0;
          borrow_d = 1'b0;
          state_d  = ST_CMP;
        end else begin
          borrow_d = step_s[4];
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    out_valid_d = (state_d == ST_DONE);
    in_ready_d  = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      borrow_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      neg_q       <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      borrow_q    <= borrow_d;
      a_q         <= a_d;
      b_q         <= b_d;
      diff_q      <= diff_d;
      neg_q       <= neg_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign neg       = neg_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcdsub_seq.sv
// Directed bench for bcdsub_seq: decimal reference model feeding a scoreboard queue.
module tb_bcdsub_seq;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         neg;
  logic         err;

  typedef struct {
    logic [W-1:0] diff;
    logic         neg;
    logic         err;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   total = 0;
  int   bad = 0;

  bcdsub_seq #(.NDIG(NDIG)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    logic [W-1:0] t = v;
    for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(t[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    logic bad_nib = 1'b0;
    for (int i = 0; i < NDIG; i++)
      if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) bad_nib = 1'b1;
    if (bad_nib) begin
      e.diff = '0; e.neg = 1'b0; e.err = 1'b1; e.lat = 1;
    end else if (bcd2int(av) < bcd2int(bv)) begin
      e.diff = int2bcd(bcd2int(bv) - bcd2int(av)); e.neg = 1'b1; e.err = 1'b0;
      e.lat = 2 * NDIG + 1;
    end else begin
      e.diff = int2bcd(bcd2int(av) - bcd2int(bv)); e.neg = 1'b0; e.err = 1'b0;
      e.lat = NDIG + 1;
    end
    return e;
  endfunction

  // Presents operands, checks the accept, then waits (bounded) for the result.
  task automatic run_until_result(input logic [W-1:0] av, input logic [W-1:0] bv);
    int cyc;
    exp_q.push_back(model(av, bv));
    @(negedge clk);
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    chk("accept_in_ready_low", 32'(in_ready), 32'd0);
    while (!out_valid && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
    last_exp = exp_q.pop_front();
    chk("latency", 32'(cyc), 32'(last_exp.lat));
    chk("diff", 32'(diff), 32'(last_exp.diff));
    chk("neg", 32'(neg), 32'(last_exp.neg));
    chk("err", 32'(err), 32'(last_exp.err));
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    run_until_result(av, bv);
    release_out();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_diff"}, 32'(diff), 32'd0);
    chk({tag, "_neg"}, 32'(neg), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    reset_n = 1'b1;

    do_op(16'h0042, 16'h0017);
    do_op(16'h0017, 16'h0042);
    do_op(16'h1000, 16'h0001);
    do_op(16'h0000, 16'h0001);
    do_op(16'h9999, 16'h9999);
    do_op(16'h00A0, 16'h0001);
    do_op(16'h0001, 16'hF000);
    do_op(16'h9999, 16'h0000);
    do_op(16'h0000, 16'h9999);

    for (int k = 0; k < 6; k++) begin
      logic [W-1:0] ra, rb;
      ra = int2bcd(int'($urandom_range(0, 9999)));
      rb = int2bcd(int'($urandom_range(0, 9999)));
      do_op(ra, rb);
    end

    // Back-pressure: result must hold and new operands must be refused.
    run_until_result(16'h0042, 16'h0017);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = k[0];
      a = 16'h1111; b = 16'h2222;
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_diff", 32'(diff), 32'(last_exp.diff));
      chk("bp_neg", 32'(neg), 32'(last_exp.neg));
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_out();
    do_op(16'h0500, 16'h0250);

    // Asynchronous reset during the second SUB digit.
    @(negedge clk);
    a = 16'h0017; b = 16'h0042; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    do_op(16'h0042, 16'h0017);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
